// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core slice: opcodes, functs, fetch FSM
// state type, default reset PC and the branch-offset helper.
package mips_pkg;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] FN_JR   = 6'h08;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic {
        FETCH,
        EXEC
    } fetch_state_t;

    // Sign-extended word offset of a branch immediate.
    function automatic logic [31:0] br_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC selection: jr > jump > taken branch > sequential.
// Ports: pc_plus4, target (instr[25:0]), control bits, alu_zero, rs_data -> next_pc, misalign.
module next_pc_sel
    import mips_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [25:0] target,
    input  logic        jump,
    input  logic        branch,
    input  logic        nequal,
    input  logic        jr,
    input  logic        alu_zero,
    input  logic [31:0] rs_data,
    output logic [31:0] next_pc,
    output logic        misalign
);

    logic taken;

    always_comb begin
        taken    = branch & (alu_zero ^ nequal);
        misalign = jr & (|rs_data[1:0]);
        next_pc  = pc_plus4;
        priority case (1'b1)
            jr:      next_pc = {rs_data[31:2], 2'b00};
            jump:    next_pc = {pc_plus4[31:28], target, 2'b00};
            taken:   next_pc = pc_plus4 + br_offset(target[15:0]);
            default: next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch / next-PC stage: owns the PC, fetches over req/ready,
// holds instr while the core executes, and advances the PC on exec_done.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr,
    output logic             instr_valid,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    input  logic             exec_done,
    input  logic             jump,
    input  logic             branch,
    input  logic             nequal,
    input  logic             jr,
    input  logic             alu_zero,
    input  logic [31:0]      rs_data,
    output logic             align_err,
    output logic [CNT_W-1:0] retired
);

    fetch_state_t state;
    logic [31:0]  next_pc;
    logic         misalign;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;

    next_pc_sel u_sel (
        .pc_plus4 (pc_plus4),
        .target   (instr[25:0]),
        .jump     (jump),
        .branch   (branch),
        .nequal   (nequal),
        .jr       (jr),
        .alu_zero (alu_zero),
        .rs_data  (rs_data),
        .next_pc  (next_pc),
        .misalign (misalign)
    );

    // imem_req is registered so it stays low for the whole reset and
    // rises on the first edge after release; ready is only honoured
    // while req is already high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            instr       <= 32'd0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            align_err   <= 1'b0;
            retired     <= '0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (imem_req && imem_ready) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= EXEC;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                EXEC: begin
                    if (exec_done) begin
                        pc          <= next_pc;
                        retired     <= retired + CNT_W'(1);
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= FETCH;
                        if (misalign)
                            align_err <= 1'b1;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule
